replacement_policy: RTL and testbench

Parametrised per-set replacement-state unit for the L1 cache controllers. It supports true-LRU and FIFO modes, with a configurable way count and set count. Rank state is held in an internal synchronous-read RAM, updated read-modify-write with full forwarding, and initialised by a hardware sweep after reset. The block sits beside the tag arrays and supplies the victim way on a miss.

---
 rtl/replacement_policy.sv | 152 +++++++++++++++
 tb/tb_replacement_policy.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/replacement_policy.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | replacement_policy                                                       |
// | Per-set true-LRU / FIFO rank store with RMW forwarding and init sweep.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module replacement_policy #(
    parameter int WAYS       = 4,
    parameter int INDEX_BITS = 8,
    parameter int MODE       = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic                    init_busy,
    input  logic                    access_valid,
    input  logic [INDEX_BITS-1:0]   access_index,
    input  logic [$clog2(WAYS)-1:0] access_way,
    input  logic                    access_fill,
    input  logic                    query_valid,
    input  logic [INDEX_BITS-1:0]   query_index,
    output logic                    victim_valid,
    output logic [$clog2(WAYS)-1:0] victim_way,
    output logic [WAYS-1:0]         victim_onehot
);

    localparam int c_rb    = $clog2(WAYS);
    localparam int c_depth = 1 << INDEX_BITS;
    localparam int c_ew    = WAYS * c_rb;

    localparam logic [1:0] c_st_rst   = 2'd0;
    localparam logic [1:0] c_st_init  = 2'd1;
    localparam logic [1:0] c_st_ready = 2'd2;

    function automatic logic [c_ew-1:0] f_identity();
        logic [c_ew-1:0] v;
        v = '0;
        for (int i = 0; i < WAYS; i++) begin
            v[i*c_rb +: c_rb] = c_rb'(i);
        end
        return v;
    endfunction

    localparam logic [c_ew-1:0] c_identity = f_identity();

    logic [1:0]            r_state;
    logic [INDEX_BITS-1:0] r_init_idx;
    logic [c_ew-1:0]       r_mem [c_depth];

    logic                  r_s1_valid;
    logic [INDEX_BITS-1:0] r_s1_index;
    logic [c_rb-1:0]       r_s1_way;
    logic [c_ew-1:0]       r_s1_rdata;
    logic                  r_wb_valid;
    logic [INDEX_BITS-1:0] r_wb_index;
    logic [c_ew-1:0]       r_wb_ranks;
    logic                  r_q_valid;
    logic [INDEX_BITS-1:0] r_q_index;
    logic [c_ew-1:0]       r_q_rdata;

    logic                  w_ready;
    logic                  w_sweep;
    logic                  w_acc_eff;
    logic [c_ew-1:0]       w_s1_base;
    logic [c_rb-1:0]       w_acc_rank;
    logic [c_ew-1:0]       w_new_ranks;
    logic [c_ew-1:0]       w_q_ranks;
    logic [c_rb-1:0]       w_victim_way;
    logic [WAYS-1:0]       w_victim_onehot;

    // The first cycle with reset released already writes set 0, so the
    // sweep occupies exactly DEPTH busy cycles.
    assign w_ready   = reset & (r_state == c_st_ready);
    assign w_sweep   = reset & (r_state != c_st_ready);
    assign init_busy = ~w_ready;
    assign w_acc_eff = access_valid & w_ready & ((MODE == 0) | access_fill);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= c_st_rst;
            r_init_idx <= '0;
        end else begin
            case (r_state)
                c_st_rst, c_st_init: begin
                    r_init_idx <= r_init_idx + 1'b1;
                    r_state    <= (&r_init_idx) ? c_st_ready : c_st_init;
                end
                c_st_ready: r_state <= c_st_ready;
                default:    r_state <= c_st_rst;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_sweep) begin
            r_mem[r_init_idx] <= c_identity;
        end else if (r_s1_valid) begin
            r_mem[r_s1_index] <= w_new_ranks;
        end
        r_s1_rdata <= r_mem[access_index];
        r_q_rdata  <= r_mem[query_index];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_wb_valid <= 1'b0;
            r_q_valid  <= 1'b0;
        end else begin
            r_s1_valid <= w_acc_eff;
            r_wb_valid <= r_s1_valid;
            r_q_valid  <= query_valid & w_ready;
        end
        r_s1_index <= access_index;
        r_s1_way   <= access_way;
        r_wb_index <= r_s1_index;
        r_wb_ranks <= w_new_ranks;
        r_q_index  <= query_index;
    end

    // r_wb holds the write that landed on the same edge the RAM was read,
    // so it is the only value that can be newer than the read data.
    always_comb begin
        w_s1_base   = (r_wb_valid && (r_wb_index == r_s1_index)) ? r_wb_ranks : r_s1_rdata;
        w_acc_rank  = w_s1_base[r_s1_way*c_rb +: c_rb];
        w_new_ranks = w_s1_base;
        for (int i = 0; i < WAYS; i++) begin
            if (c_rb'(i) == r_s1_way) begin
                w_new_ranks[i*c_rb +: c_rb] = '0;
            end else if (w_s1_base[i*c_rb +: c_rb] < w_acc_rank) begin
                w_new_ranks[i*c_rb +: c_rb] = w_s1_base[i*c_rb +: c_rb] + 1'b1;
            end
        end
    end

    always_comb begin
        w_q_ranks       = (r_wb_valid && (r_wb_index == r_q_index)) ? r_wb_ranks : r_q_rdata;
        w_victim_way    = '0;
        w_victim_onehot = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (w_q_ranks[i*c_rb +: c_rb] == c_rb'(WAYS - 1)) begin
                w_victim_way       = c_rb'(i);
                w_victim_onehot[i] = 1'b1;
            end
        end
    end

    assign victim_valid  = r_q_valid;
    assign victim_way    = r_q_valid ? w_victim_way : '0;
    assign victim_onehot = r_q_valid ? w_victim_onehot : '0;

endmodule
`default_nettype wire

// File: tb/tb_replacement_policy.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_replacement_policy                                                    |
// | Scoreboarded bench for LRU (dut0) and FIFO (dut1) replacement units.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_replacement_policy;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       busy0, av0, af0, qv0, vv0;
    logic [7:0] ai0, qi0;
    logic [1:0] aw0, vw0;
    logic [3:0] vo0;
    logic       busy1, av1, af1, qv1, vv1;
    logic [7:0] ai1, qi1;
    logic [1:0] aw1, vw1;
    logic [3:0] vo1;

    int tests = 0;
    int fails = 0;
    int exp0_q[$];
    int exp1_q[$];
    int e0, e1, n0, n1;

    replacement_policy #(.WAYS(4), .INDEX_BITS(8), .MODE(0)) u_dut0 (
        .clock(clk), .reset(reset), .init_busy(busy0),
        .access_valid(av0), .access_index(ai0), .access_way(aw0), .access_fill(af0),
        .query_valid(qv0), .query_index(qi0),
        .victim_valid(vv0), .victim_way(vw0), .victim_onehot(vo0)
    );

    replacement_policy #(.WAYS(4), .INDEX_BITS(8), .MODE(1)) u_dut1 (
        .clock(clk), .reset(reset), .init_busy(busy1),
        .access_valid(av1), .access_index(ai1), .access_way(aw1), .access_fill(af1),
        .query_valid(qv1), .query_index(qi1),
        .victim_valid(vv1), .victim_way(vw1), .victim_onehot(vo1)
    );

    // Monitors: every victim pulse must match the oldest outstanding query.
    always @(negedge clk) begin
        if (vv0) begin
            tests++;
            if (exp0_q.size() == 0) begin
                fails++;
                $display("FAIL dut0 unexpected victim: got way %0d onehot %b, required no response", vw0, vo0);
            end else begin
                e0 = exp0_q.pop_front();
                if (vw0 !== 2'(e0) || vo0 !== 4'(1 << e0)) begin
                    fails++;
                    $display("FAIL dut0 victim: got way %0d onehot %b, required way %0d onehot %b",
                             vw0, vo0, e0, 4'(1 << e0));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (vv1) begin
            tests++;
            if (exp1_q.size() == 0) begin
                fails++;
                $display("FAIL dut1 unexpected victim: got way %0d onehot %b, required no response", vw1, vo1);
            end else begin
                e1 = exp1_q.pop_front();
                if (vw1 !== 2'(e1) || vo1 !== 4'(1 << e1)) begin
                    fails++;
                    $display("FAIL dut1 victim: got way %0d onehot %b, required way %0d onehot %b",
                             vw1, vo1, e1, 4'(1 << e1));
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        av0 = 1'b0; qv0 = 1'b0; av1 = 1'b0; qv1 = 1'b0;
    endtask

    task automatic acc0(input int idx, input int way, input bit fill);
        av0 = 1'b1; ai0 = 8'(idx); aw0 = 2'(way); af0 = fill;
    endtask

    task automatic acc1(input int idx, input int way, input bit fill);
        av1 = 1'b1; ai1 = 8'(idx); aw1 = 2'(way); af1 = fill;
    endtask

    task automatic qry0(input int idx, input int exp_way);
        qv0 = 1'b1; qi0 = 8'(idx); exp0_q.push_back(exp_way);
    endtask

    task automatic qry1(input int idx, input int exp_way);
        qv1 = 1'b1; qi1 = 8'(idx); exp1_q.push_back(exp_way);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " dut0 init_busy"}, int'(busy0), 1);
        chk({tag, " dut0 victim_valid"}, int'(vv0), 0);
        chk({tag, " dut0 victim_way"}, int'(vw0), 0);
        chk({tag, " dut0 victim_onehot"}, int'(vo0), 0);
        chk({tag, " dut1 init_busy"}, int'(busy1), 1);
        chk({tag, " dut1 victim_valid"}, int'(vv1), 0);
    endtask

    // Counts busy cycles while hammering set 0 with fills and queries that
    // must all be dropped; bounded so a stuck init still terminates.
    task automatic count_init(output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (busy0) c0++;
            if (busy1) c1++;
            if (!busy0 && !busy1) break;
            av0 = 1'b1; ai0 = 8'd0; aw0 = 2'd3; af0 = 1'b1; qv0 = 1'b1; qi0 = 8'd0;
            av1 = 1'b1; ai1 = 8'd0; aw1 = 2'd3; af1 = 1'b1; qv1 = 1'b1; qi1 = 8'd0;
        end
        av0 = 1'b0; qv0 = 1'b0; av1 = 1'b0; qv1 = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        av0 = 1'b0; af0 = 1'b0; qv0 = 1'b0; ai0 = '0; aw0 = '0; qi0 = '0;
        av1 = 1'b0; af1 = 1'b0; qv1 = 1'b0; ai1 = '0; aw1 = '0; qi1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        count_init(n0, n1);
        chk("dut0 init busy cycles", n0, 256);
        chk("dut1 init busy cycles", n1, 256);

        // Freshly initialised sets report way 3, back-to-back.
        qry0(0, 3);   qry1(0, 3);   step();
        qry0(37, 3);  qry1(37, 3);  step();
        qry0(255, 3); qry1(255, 3); step();

        // LRU on set 5 with same-cycle queries seeing only earlier hits.
        acc0(5, 3, 0);              step();
        acc0(5, 0, 0); qry0(5, 2);  step();
        acc0(5, 2, 0); qry0(5, 2);  step();
        qry0(5, 1);                 step();
        acc0(5, 1, 0);              step();
        qry0(5, 3);                 step();

        // FIFO on set 9: hits never move ranks.
        qry1(9, 3);                 step();
        acc1(9, 3, 1);              step();
        acc1(9, 0, 0);              step();
        acc1(9, 1, 0);              step();
        acc1(9, 2, 0);              step();
        qry1(9, 2);                 step();
        acc1(9, 2, 1);              step();
        qry1(9, 1);                 step();

        // Back-to-back accesses to set 7 -> ranks [2,0,3,1].
        acc0(7, 3, 0); acc1(20, 3, 1); step();
        acc0(7, 3, 0); acc1(20, 3, 1); step();
        acc0(7, 1, 0); acc1(20, 1, 1); step();
        qry0(7, 2); acc0(7, 2, 0); qry1(20, 2); step();
        qry0(7, 0); acc0(7, 0, 0);             step();
        qry0(7, 3);                            step();

        // Same accesses on set 17 with idle gaps must agree.
        acc0(17, 3, 0); repeat (3) step();
        acc0(17, 3, 0); repeat (3) step();
        acc0(17, 1, 0); repeat (3) step();
        qry0(17, 2);    step();

        // Access and query to the same set in one cycle.
        acc0(4, 3, 0); qry0(4, 3); step();
        qry0(4, 2);                step();

        repeat (4) step();
        chk("dut0 queue drained", exp0_q.size(), 0);
        chk("dut1 queue drained", exp1_q.size(), 0);

        // Reset in the middle of a sweep restarts it from set 0.
        reset = 1'b0; step(); step();
        reset = 1'b1; repeat (100) step();
        reset = 1'b0; step();
        @(negedge clk);
        chk_reset_outputs("mid-sweep reset");
        step();
        reset = 1'b1;
        count_init(n0, n1);
        chk("dut0 re-init busy cycles", n0, 256);
        chk("dut1 re-init busy cycles", n1, 256);

        qry0(0, 3); qry1(0, 3); step();
        qry0(5, 3); qry1(9, 3); step();
        qry0(7, 3);             step();
        repeat (4) step();
        chk("dut0 final queue drained", exp0_q.size(), 0);
        chk("dut1 final queue drained", exp1_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
